fc_backward: RTL and testbench
==============================

# fc_backward

Sequential backward-pass (transpose) engine for the fully connected layer: computes the input gradient dX = Wᵀ·dZ in the same signed fixed-point format as the forward layer. A single time-multiplexed MAC replaces the forward block's fully parallel array. dZ is loaded serially, weights stream in column-major order, and dX words stream out one per column. The block sits between the loss/next-layer gradient source and the upstream layer's gradient sink.

## Interface
- WORD_SIZE, 16, data word width (signed, two's complement)
- LAYER_SIZE, 128, vector length N (dZ, dX) and weight matrix dimension N×N
- INT_SLICE, 8, integer bits; DEC_SLICE = WORD_SIZE − INT_SLICE fractional bits
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  begin a pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- dz_valid / dz_ready  in / out  1 / 1  dZ load handshake
- dz_data  in  WORD_SIZE  dZ[i], i = 0..N−1 in order
- w_valid / w_ready  in / out  1 / 1  weight handshake
- w_data  in  WORD_SIZE  W[i][j], order j outer, i inner
- dx_valid / dx_ready  out / in  1 / 1  result handshake
- dx_data  out  WORD_SIZE  dX[j]
- dx_index  out  clog2(LAYER_SIZE)  j of current dx_data
- done  out  1  one-cycle pulse after last dX accepted

## Operation
- States: IDLE → LOAD → ACC ⇄ OUT → IDLE.
- IDLE: all ready/valid low. start=1 → LOAD, i=j=0. start in any other state is ignored.
- LOAD: dz_ready=1. Each dz_valid&dz_ready stores dz_buf[i] and increments i. After word N−1: i=0, acc=0, go to ACC.
- ACC: w_ready=1. Each w_valid&w_ready adds trunc(dz_buf[i]·w_data) to acc and increments i. After i=N−1 is accepted: go to OUT, i=0.
- OUT: w_ready=0, dx_valid=1, dx_data=fmt(acc), dx_index=j. On dx_ready:
  - j=N−1 → done pulse, go to IDLE;
  - otherwise j++, acc=0, go to ACC.
- Product rule, matching the forward layer (truncation toward zero):
  - full signed 2·WORD_SIZE product P;
  - take |P| and its bits [WORD_SIZE+DEC_SLICE−1 : DEC_SLICE];
  - re-apply the sign by two's complement;
  - sign-extend the WORD_SIZE result into acc.
- acc width: WORD_SIZE + clog2(LAYER_SIZE), two's complement, never overflows.
- fmt(acc): see Configuration.
- dZ is not bias-related; no bias input is used. The bias gradient equals dZ and is handled outside this block.

## Timing
- Reset values:
  - outputs: busy, dz_ready, w_ready, dx_valid, done = 0; dx_data = 0; dx_index = 0;
  - internal: state=IDLE, i=j=0, acc=0, dz_buf contents don't-care.
- Reset asserted mid-pass aborts immediately. No done pulse. The next start runs a full, correct pass.
- Throughput: 1 dZ word per cycle in LOAD; 1 weight per cycle in ACC.
- dx_valid rises on the cycle after the N-th weight of a column is accepted. Full pass with no stalls: N + N·(N+1) cycles after start.
- dx_data and dx_index are stable while dx_valid & !dx_ready. dx_valid never drops without acceptance.
- Gaps in dz_valid or w_valid only stall the engine; there is no timeout.
- done is high exactly on the cycle after the final acceptance, together with busy=0.

## Configuration
- FC_BWD_SAT_EN undefined: dx_data = acc[WORD_SIZE−1:0]. Modulo wrap, bit-identical to the forward layer's accumulation.
- FC_BWD_SAT_EN defined: acc is clamped to the signed WORD_SIZE range [0x8000, 0x7FFF] for 16-bit words before output.

## Test plan
- LAYER_SIZE=2, dZ={0x0100, 0x0200}, all W=0x0100 -> dX[0]=dX[1]=0x0300, dx_index 0 then 1, done pulse once.
- LAYER_SIZE=2, dZ={0xFFFF, 0x0000}, W[0][0]=0x0080 (−1/256·0.5), other W=0 -> dX[0]=0x0000 (toward zero, not 0xFFFF).
- Hold dx_ready=0 for 5 cycles in OUT -> dx_valid, dx_data, dx_index constant; w_ready=0 throughout.
- LAYER_SIZE=2, dZ={0x7F00, 0x7F00}, all W=0x0100 -> dX=0xFE00 without FC_BWD_SAT_EN; 0x7FFF with it.
- Assert rst during ACC of column 1 -> all outputs 0 asynchronously; following pass with the first test's vectors gives 0x0300, 0x0300.
- Random w_valid/dz_valid gaps with LAYER_SIZE=4, random data -> dX matches the reference model; start pulses while busy are ignored.

Source files
------------

// File: rtl/fc_backward.sv
// fc_backward: sequential transpose engine for the fully connected layer backward pass.
// Computes dX = W^T * dZ with a single time-multiplexed MAC in signed fixed point
// (WORD_SIZE bits, INT_SLICE integer bits, WORD_SIZE-INT_SLICE fractional bits).
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 begin a pass (sampled only when idle)
//   busy                  high whenever the engine is not idle
//   dz_valid/ready/data   serial dZ load, dZ[0] .. dZ[N-1]
//   w_valid/ready/data    weight stream W[i][j], column j outer, row i inner
//   dx_valid/ready/data   one dX word per column
//   dx_index              column index j of the presented dx_data
//   done                  one-cycle pulse after the last dX word is accepted
//
// Build option: define FC_BWD_SAT_EN to clamp each dX to the signed WORD_SIZE range;
// otherwise dX is the low WORD_SIZE bits of the accumulator (modulo wrap).

module fc_backward #(
    parameter int WORD_SIZE  = 16,
    parameter int LAYER_SIZE = 128,
    parameter int INT_SLICE  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    input  logic                          dz_valid,
    output logic                          dz_ready,
    input  logic [WORD_SIZE-1:0]          dz_data,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [WORD_SIZE-1:0]          w_data,
    output logic                          dx_valid,
    input  logic                          dx_ready,
    output logic [WORD_SIZE-1:0]          dx_data,
    output logic [$clog2(LAYER_SIZE)-1:0] dx_index,
    output logic                          done
);

    localparam int DEC_SLICE = WORD_SIZE - INT_SLICE;
    localparam int IDX_W     = $clog2(LAYER_SIZE);
    localparam int ACC_W     = WORD_SIZE + IDX_W;
    localparam int PROD_W    = 2 * WORD_SIZE;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StAcc, StOut} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        i_q, i_d;
    logic [IDX_W-1:0]        j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    done_q, done_d;

    logic [WORD_SIZE-1:0]    dz_buf [LAYER_SIZE];

    // Truncated fixed-point product of dz_buf[i] and the incoming weight
    logic [WORD_SIZE-1:0]    dz_cur;
    logic signed [PROD_W-1:0] dz_ext, w_ext, prod;
    logic [PROD_W-1:0]       prod_mag;
    logic [WORD_SIZE-1:0]    mag_slice, term_w;
    logic signed [ACC_W-1:0] term;
    logic [WORD_SIZE-1:0]    dx_fmt;

    always_comb begin
        dz_cur    = dz_buf[i_q];
        dz_ext    = {{WORD_SIZE{dz_cur[WORD_SIZE-1]}}, dz_cur};
        w_ext     = {{WORD_SIZE{w_data[WORD_SIZE-1]}}, w_data};
        prod      = dz_ext * w_ext;
        // Slicing the magnitude, then re-signing, rounds toward zero rather than down
        prod_mag  = prod[PROD_W-1] ? -prod : prod;
        mag_slice = prod_mag[WORD_SIZE+DEC_SLICE-1:DEC_SLICE];
        term_w    = prod[PROD_W-1] ? -mag_slice : mag_slice;
        term      = {{IDX_W{term_w[WORD_SIZE-1]}}, term_w};
    end

`ifdef FC_BWD_SAT_EN
    // Accumulator fits a word only when all bits from the word's sign bit upward agree
    logic [IDX_W:0] acc_top;

    always_comb begin
        acc_top = acc_q[ACC_W-1:WORD_SIZE-1];
        if (acc_top == '0 || acc_top == '1) begin
            dx_fmt = acc_q[WORD_SIZE-1:0];
        end else if (acc_q[ACC_W-1]) begin
            dx_fmt = {1'b1, {(WORD_SIZE-1){1'b0}}};
        end else begin
            dx_fmt = {1'b0, {(WORD_SIZE-1){1'b1}}};
        end
    end
`else
    always_comb begin
        dx_fmt = acc_q[WORD_SIZE-1:0];
    end
`endif

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        busy     = (state_q != StIdle);
        dz_ready = 1'b0;
        w_ready  = 1'b0;
        dx_valid = 1'b0;
        dx_data  = '0;
        dx_index = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            StLoad: begin
                dz_ready = 1'b1;
                if (dz_valid) begin
                    if (i_q == LAST_IDX) begin
                        i_d     = '0;
                        acc_d   = '0;
                        state_d = StAcc;
                    end else begin
                        i_d = i_q + IDX_ONE;
                    end
                end
            end
            StAcc: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    acc_d = acc_q + term;
                    if (i_q == LAST_IDX) begin
                        i_d     = '0;
                        state_d = StOut;
                    end else begin
                        i_d = i_q + IDX_ONE;
                    end
                end
            end
            StOut: begin
                dx_valid = 1'b1;
                dx_data  = dx_fmt;
                dx_index = j_q;
                if (dx_ready) begin
                    acc_d = '0;
                    if (j_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        j_d     = j_q + IDX_ONE;
                        state_d = StAcc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    // dZ storage carries no reset; it is always fully rewritten before use
    always_ff @(posedge clk) begin
        if (state_q == StLoad && dz_valid) begin
            dz_buf[i_q] <= dz_data;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_fc_backward.sv
// Self-checking bench for fc_backward with LAYER_SIZE=4. Expected dX values come
// from a plain-arithmetic model of the transpose product; inputs are driven and
// outputs sampled on the falling clock edge.

`timescale 1ns/1ps

module tb_fc_backward;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int DEC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          dz_valid, dz_ready;
    logic [W-1:0]  dz_data;
    logic          w_valid, w_ready;
    logic [W-1:0]  w_data;
    logic          dx_valid, dx_ready;
    logic [W-1:0]  dx_data;
    logic [1:0]    dx_index;
    logic          done;

    always #5 clk = ~clk;

    fc_backward #(
        .WORD_SIZE  (W),
        .LAYER_SIZE (N),
        .INT_SLICE  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .dz_valid (dz_valid),
        .dz_ready (dz_ready),
        .dz_data  (dz_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .dx_valid (dx_valid),
        .dx_ready (dx_ready),
        .dx_data  (dx_data),
        .dx_index (dx_index),
        .done     (done)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] dz_v [N];
    logic [W-1:0] w_v  [N][N];   // w_v[i][j] = W[i][j]
    logic [W-1:0] exp_dx [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fixed-point product with truncation toward zero, as a signed word
    function automatic int trunc_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int p, m, r;
        p = int'($signed(a)) * int'($signed(b));
        m = (p < 0) ? -p : p;
        m = (m / 256) % 65536;
        r = (p < 0) ? ((65536 - m) % 65536) : m;
        if (r >= 32768) r = r - 65536;
        return r;
    endfunction

    task automatic compute_exp();
        for (int j = 0; j < N; j++) begin
            int s;
            s = 0;
            for (int i = 0; i < N; i++) s += trunc_mul(dz_v[i], w_v[i][j]);
`ifdef FC_BWD_SAT_EN
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`endif
            exp_dx[j] = W'(s);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_dz_ready"}, dz_ready, 0);
        check_eq({tag, "_w_ready"}, w_ready, 0);
        check_eq({tag, "_dx_valid"}, dx_valid, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_dx_data"}, dx_data, 0);
        check_eq({tag, "_dx_index"}, dx_index, 0);
    endtask

    // One pass. gap_pct: chance an input valid is withheld; rdy_pct: chance dx_ready
    // is offered; hold: forced stall cycles per dX word; abort: reset after the first
    // weight of column 1; ign_start: toggle start while busy; exp_cycles > 0 checks latency.
    task automatic run_pass(input int gap_pct, input int rdy_pct, input int hold,
                            input bit abort, input bit ign_start, input int exp_cycles);
        int k, wc, xj, cyc, stall;
        bit pending;
        compute_exp();
        k = 0; wc = 0; xj = 0; cyc = 0; stall = 0; pending = 0;
        @(negedge clk);
        start = 1'b1;
        while (xj < N && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            check_eq("done_low", done, 0);
            check_eq("busy_high", busy, 1);
            if (pending) check_eq("dx_valid_held", dx_valid, 1);
            if (dx_valid) begin
                check_eq("dx_index", dx_index, xj);
                check_eq("dx_data", dx_data, exp_dx[xj]);
                check_eq("w_ready_in_out", w_ready, 0);
            end
            if (abort && wc == N + 1) begin
                rst = 1'b1;
                #1;
                check_all_zero("async_rst");
                dz_valid = 1'b0;
                w_valid  = 1'b0;
                dx_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            dz_valid = (k < N) && ($urandom_range(99) >= gap_pct);
            if (k < N) dz_data = dz_v[k];
            else dz_data = W'($urandom);
            w_valid = (wc < N * N) && ($urandom_range(99) >= gap_pct);
            if (wc < N * N) w_data = w_v[wc % N][wc / N];
            else w_data = W'($urandom);
            if (dx_valid) dx_ready = (stall >= hold) && ($urandom_range(99) < rdy_pct);
            else dx_ready = 1'($urandom_range(1));
            if (ign_start) start = 1'($urandom_range(1));
            if (dz_valid && dz_ready) k++;
            if (w_valid && w_ready) wc++;
            if (dx_valid && dx_ready) begin
                xj++;
                stall = 0;
                pending = 0;
            end else if (dx_valid) begin
                stall++;
                pending = 1;
            end else begin
                pending = 0;
            end
        end
        if (xj < N) begin
            check_eq("pass_timeout", xj, N);
        end else begin
            @(negedge clk);
            start = 1'b0;
            check_eq("done_pulse", done, 1);
            check_eq("busy_after", busy, 0);
            if (exp_cycles > 0) check_eq("pass_cycles", cyc, exp_cycles);
            @(negedge clk);
            check_eq("done_clear", done, 0);
        end
        dz_valid = 1'b0;
        w_valid  = 1'b0;
        dx_ready = 1'b0;
    endtask

    task automatic set_w_all(input logic [W-1:0] v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) w_v[i][j] = v;
    endtask

    task automatic set_basic();
        dz_v = '{16'h0100, 16'h0200, 16'h0000, 16'h0000};
        set_w_all(16'h0100);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        dz_valid = 1'b0; dz_data = '0;
        w_valid = 1'b0; w_data = '0; dx_ready = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // Basic sum with latency check, no stalls
        set_basic();
        run_pass(0, 100, 0, 0, 0, N + N * (N + 1));

        // Small negative product truncates toward zero
        dz_v = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        set_w_all(16'h0000);
        w_v[0][0] = 16'h0080;
        run_pass(0, 100, 0, 0, 0, 0);

        // Output held for 5 cycles per column
        set_basic();
        run_pass(0, 100, 5, 0, 0, 0);

        // Word overflow: wrap or clamp
        dz_v = '{16'h7F00, 16'h7F00, 16'h0000, 16'h0000};
        set_w_all(16'h0100);
        run_pass(0, 100, 0, 0, 0, 0);

        // Reset mid-pass, then a clean pass
        set_basic();
        run_pass(0, 100, 0, 1, 0, 0);
        @(negedge clk);
        check_all_zero("post_abort");
        run_pass(0, 100, 0, 0, 0, N + N * (N + 1));

        // Random data with handshake gaps and spurious start pulses
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) begin
                dz_v[i] = W'($urandom);
                for (int j = 0; j < N; j++) w_v[i][j] = W'($urandom);
            end
            run_pass(30, 70, 0, 0, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
